// File: rtl/alu_pkg.sv
// Shared encodings for the miniRV multi-cycle execute unit.
package alu_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative RV32M datapath: one shift-add or restoring-divide step per cycle,
// with sign fix-up and divide-by-zero / overflow overrides on the final step.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            done_c,
    output logic [XLEN-1:0] result_c
);

    localparam int unsigned CW = $clog2(XLEN);
    localparam int unsigned AW = 2 * XLEN;
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);

    logic [2:0]      funct3_q, funct3_d;
    logic            busy_q, busy_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [XLEN-1:0] opb_q, opb_d;
    logic [XLEN-1:0] a_orig_q, a_orig_d;
    logic            neg_res_q, neg_res_d;
    logic            neg_rem_q, neg_rem_d;
    logic            div_zero_q, div_zero_d;
    logic            ovf_q, ovf_d;

    logic            a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN:0]   mul_sum, div_sh;
    logic [XLEN-1:0] div_sub;
    logic            div_ge;
    logic [AW-1:0]   mul_step, div_step, step_acc, prod;
    logic [XLEN-1:0] quo_fix, rem_fix;

    // Operand signedness and magnitudes for the op being started.
    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (funct3)
            F3_MUL, F3_MULH, F3_DIV, F3_REM: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            F3_MULHSU:                  a_signed = 1'b1;
            F3_MULHU, F3_DIVU, F3_REMU: ;
            default: ;
        endcase
        a_neg = a_signed & op_a[XLEN-1];
        b_neg = b_signed & op_b[XLEN-1];
        a_mag = a_neg ? -op_a : op_a;
        b_mag = b_neg ? -op_b : op_b;
    end

    // One iteration: acc holds {hi, lo} = {partial product, multiplier} or {remainder, quotient}.
    always_comb begin
        mul_sum  = {1'b0, acc_q[AW-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_step = {mul_sum, acc_q[XLEN-1:1]};
        div_sh   = acc_q[AW-1:XLEN-1];
        div_ge   = div_sh >= {1'b0, opb_q};
        div_sub  = div_sh[XLEN-1:0] - opb_q;
        div_step = {(div_ge ? div_sub : div_sh[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
        step_acc = funct3_q[2] ? div_step : mul_step;
    end

    // Final result from the last step, with sign fix and overrides.
    always_comb begin
        prod    = neg_res_q ? -step_acc : step_acc;
        quo_fix = neg_res_q ? -step_acc[XLEN-1:0] : step_acc[XLEN-1:0];
        rem_fix = neg_rem_q ? -step_acc[AW-1:XLEN] : step_acc[AW-1:XLEN];
        if (div_zero_q) begin
            quo_fix = '1;
            rem_fix = a_orig_q;
        end else if (ovf_q) begin
            quo_fix = MIN_VAL;
            rem_fix = '0;
        end
        if (funct3_q[2]) begin
            result_c = funct3_q[1] ? rem_fix : quo_fix;
        end else begin
            result_c = (funct3_q == F3_MUL) ? prod[XLEN-1:0] : prod[AW-1:XLEN];
        end
        done_c = busy_q & (cnt_q == LAST);
    end

    always_comb begin
        funct3_d   = funct3_q;
        busy_d     = busy_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opb_d      = opb_q;
        a_orig_d   = a_orig_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        ovf_d      = ovf_q;
        if (start) begin
            funct3_d   = funct3;
            busy_d     = 1'b1;
            cnt_d      = '0;
            acc_d      = {{XLEN{1'b0}}, a_mag};
            opb_d      = b_mag;
            a_orig_d   = op_a;
            neg_res_d  = a_neg ^ b_neg;
            neg_rem_d  = funct3[2] & a_neg;
            div_zero_d = funct3[2] & (op_b == '0);
            ovf_d      = funct3[2] & a_signed & (op_a == MIN_VAL) & (&op_b);
        end else if (busy_q) begin
            acc_d = step_acc;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            funct3_q   <= '0;
            busy_q     <= 1'b0;
            cnt_q      <= '0;
            acc_q      <= '0;
            opb_q      <= '0;
            a_orig_q   <= '0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            funct3_q   <= funct3_d;
            busy_q     <= busy_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opb_q      <= opb_d;
            a_orig_q   <= a_orig_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            ovf_q      <= ovf_d;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// miniRV execute unit: single-cycle RV32I ALU plus iterative RV32M,
// with valid/ready handshakes on both sides and a registered result.
module alu_mc
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter bit          EN_M = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] rdata1,
    input  logic [XLEN-1:0] rdata2,
    input  logic [XLEN-1:0] imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] rout
);

    localparam int unsigned SHW = $clog2(XLEN);

    state_t          state_q, state_d;
    logic [XLEN-1:0] rout_q, rout_d;
    logic            out_valid_q, out_valid_d;

    logic            in_ready_c, accept_c, is_m_c;
    logic            base_en_c, alt_en_c, arith_c;
    logic [XLEN-1:0] op_b_c, alu_res_c;
    logic [SHW-1:0]  shamt_c;
    logic            md_done_c;
    logic [XLEN-1:0] md_result_c;

    assign in_ready_c = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    assign accept_c   = in_valid & in_ready_c & ~flush;
    assign is_m_c     = EN_M & (opcode == OPC_OP) & (funct7 == F7_MULDIV);

    // Single-cycle RV32I result; unsupported encodings fall through to zero.
    always_comb begin
        op_b_c    = (opcode == OPC_OP) ? rdata2 : imm;
        shamt_c   = op_b_c[SHW-1:0];
        base_en_c = (opcode == OPC_OP_IMM) | ((opcode == OPC_OP) & (funct7 == F7_BASE));
        alt_en_c  = (opcode == OPC_OP) & (funct7 == F7_ALT);
        arith_c   = (opcode == OPC_OP_IMM) & funct7[5];
        alu_res_c = '0;
        case (funct3)
            F3_ADD: begin
                if (base_en_c)     alu_res_c = rdata1 + op_b_c;
                else if (alt_en_c) alu_res_c = rdata1 - op_b_c;
            end
            F3_SLL:  if (base_en_c) alu_res_c = rdata1 << shamt_c;
            F3_SLT:  if (base_en_c) alu_res_c = {{(XLEN-1){1'b0}}, ($signed(rdata1) < $signed(op_b_c))};
            F3_SLTU: if (base_en_c) alu_res_c = {{(XLEN-1){1'b0}}, (rdata1 < op_b_c)};
            F3_XOR:  if (base_en_c) alu_res_c = rdata1 ^ op_b_c;
            F3_SR: begin
                if (base_en_c && !arith_c)            alu_res_c = rdata1 >> shamt_c;
                else if (alt_en_c || (base_en_c && arith_c))
                    alu_res_c = XLEN'($signed(rdata1) >>> shamt_c);
            end
            F3_OR:   if (base_en_c) alu_res_c = rdata1 | op_b_c;
            F3_AND:  if (base_en_c) alu_res_c = rdata1 & op_b_c;
            default: ;
        endcase
    end

    muldiv_iter #(
        .XLEN (XLEN)
    ) u_muldiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .start    (accept_c & is_m_c),
        .funct3   (funct3),
        .op_a     (rdata1),
        .op_b     (rdata2),
        .done_c   (md_done_c),
        .result_c (md_result_c)
    );

    // Handshake FSM; a new accept overrides DONE->IDLE for back-to-back issue.
    always_comb begin
        state_d     = state_q;
        rout_d      = rout_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: ;
            CALC: begin
                if (md_done_c) begin
                    state_d     = DONE;
                    rout_d      = md_result_c;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (accept_c) begin
            if (is_m_c) begin
                state_d     = CALC;
                out_valid_d = 1'b0;
            end else begin
                state_d     = DONE;
                rout_d      = alu_res_c;
                out_valid_d = 1'b1;
            end
        end
        if (flush) begin
            state_d     = IDLE;
            rout_d      = '0;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rout_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rout_q      <= rout_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_c;
    assign out_valid = out_valid_q;
    assign rout      = rout_q;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboarded random + directed bench for alu_mc against an ISA-level model.
module tb_alu_mc;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rdata1, rdata2, imm, rout;

    always #5 clk = ~clk;

    alu_mc #(.XLEN(XLEN), .EN_M(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rdata1(rdata1), .rdata2(rdata2), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready), .rout(rout)
    );

    typedef struct {
        logic [31:0] val;
        int unsigned due;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    bit          rnd_rdy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // RV32IM semantics from plain integer arithmetic; bit 32 flags an M op.
    function automatic logic [32:0] model(input logic [6:0] op, input logic [2:0] f3,
                                          input logic [6:0] f7, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] im);
        logic [31:0] y, bb;
        logic        m;
        int          sh;
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        y = 32'h0; m = 1'b0;
        sa = longint'($signed(a)); sb = longint'($signed(b));
        ua = longint'({32'h0, a});  ub = longint'({32'h0, b});
        if (op == 7'b0010011 || (op == 7'b0110011 && f7 == 7'h00)) begin
            bb = (op == 7'b0010011) ? im : b;
            sh = int'(bb[4:0]);
            case (f3)
                3'd0: y = a + bb;
                3'd1: y = a << sh;
                3'd2: y = ($signed(a) < $signed(bb)) ? 32'd1 : 32'd0;
                3'd3: y = (a < bb) ? 32'd1 : 32'd0;
                3'd4: y = a ^ bb;
                3'd5: y = (op == 7'b0010011 && f7[5]) ? 32'($signed(a) >>> sh) : (a >> sh);
                3'd6: y = a | bb;
                default: y = a & bb;
            endcase
        end else if (op == 7'b0110011 && f7 == 7'h20) begin
            sh = int'(b[4:0]);
            if (f3 == 3'd0)      y = a - b;
            else if (f3 == 3'd5) y = 32'($signed(a) >>> sh);
        end else if (op == 7'b0110011 && f7 == 7'h01) begin
            m = 1'b1;
            case (f3)
                3'd0: begin p = 64'(sa * sb); y = p[31:0];  end
                3'd1: begin p = 64'(sa * sb); y = p[63:32]; end
                3'd2: begin p = 64'(sa * ub); y = p[63:32]; end
                3'd3: begin p = 64'(ua * ub); y = p[63:32]; end
                3'd4: y = (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
                3'd5: y = (b == 0) ? 32'hFFFF_FFFF : a / b;
                3'd6: y = (b == 0) ? a : 32'(sa % sb);
                default: y = (b == 0) ? a : a % b;
            endcase
        end
        return {m, y};
    endfunction

    // Monitor: latency is measured from the first cycle a result is visible.
    bit          seen = 1'b0;
    int unsigned vcyc = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid) begin
            if (!seen) begin
                seen = 1'b1;
                vcyc = cyc;
            end
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out_valid", {31'h0, out_valid}, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rout", rout, e.val);
                    chk("latency", vcyc, e.due);
                end
                seen = 1'b0;
            end
        end else begin
            seen = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (rnd_rdy) begin
            #1;
            if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 9))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Called at posedge+1; returns at posedge+1 of the accepting edge.
    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                         output int waited);
        logic [32:0] r;
        opcode = op; funct3 = f3; funct7 = f7; rdata1 = a; rdata2 = b; imm = im;
        in_valid = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            chk("accept_timeout", {31'h0, in_ready}, 32'h1);
        end else begin
            r = model(op, f3, f7, a, b, im);
            exp_q.push_back('{r[31:0], cyc + 1 + (r[32] ? XLEN : 0)});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        opcode = 7'($urandom); funct3 = 3'($urandom); funct7 = 7'($urandom);
        rdata1 = $urandom; rdata2 = $urandom; imm = $urandom;
    endtask

    task automatic wait_drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 300) begin
            @(posedge clk);
            w++;
        end
        #1;
        chk("drain", 32'(exp_q.size()), 32'h0);
    endtask

    localparam logic [6:0] OI = 7'b0010011;
    localparam logic [6:0] OR = 7'b0110011;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          w;
        logic [32:0] r;
        logic [6:0]  op, f7;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        opcode = '0; funct3 = '0; funct7 = '0; rdata1 = '0; rdata2 = '0; imm = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", {31'h0, out_valid}, 32'h0);
        chk("reset_rout", rout, 32'h0);
        chk("reset_in_ready", {31'h0, in_ready}, 32'h1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases.
        issue(OI, 3'd0, 7'h00, 32'd5, 32'h0, 32'hFFFF_FFFD, w);
        issue(OI, 3'd5, 7'h20, 32'h8000_0000, 32'h0, 32'h0000_0404, w);
        issue(OR, 3'd3, 7'h00, 32'd1, 32'hFFFF_FFFF, 32'h0, w);
        issue(OR, 3'd1, 7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, w);
        issue(OR, 3'd3, 7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, w);
        issue(OR, 3'd0, 7'h01, 32'd7, 32'hFFFF_FFFA, 32'h0, w);
        issue(OR, 3'd4, 7'h01, 32'hFFFF_FFF9, 32'd2, 32'h0, w);
        issue(OR, 3'd6, 7'h01, 32'hFFFF_FFF9, 32'd2, 32'h0, w);
        issue(OR, 3'd4, 7'h01, 32'h1234_5678, 32'h0, 32'h0, w);
        issue(OR, 3'd6, 7'h01, 32'h1234_5678, 32'h0, 32'h0, w);
        issue(OR, 3'd4, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, w);
        issue(OR, 3'd6, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, w);
        issue(7'b0110111, 3'd0, 7'h00, 32'h55, 32'h66, 32'h77, w);
        for (int i = 0; i < 4; i++) begin
            issue(OI, 3'd0, 7'h00, 32'(i * 3), 32'h0, 32'(i), w);
            if (i > 0) chk("b2b_single_wait", 32'(w), 32'h0);
        end
        wait_drain();

        // Back-pressure: result must hold while out_ready is low.
        out_ready = 1'b0;
        issue(OR, 3'd0, 7'h00, 32'd3, 32'd4, 32'h0, w);
        r = model(OR, 3'd0, 7'h00, 32'd3, 32'd4, 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_out_valid", {31'h0, out_valid}, 32'h1);
            chk("hold_rout", rout, r[31:0]);
            chk("hold_in_ready", {31'h0, in_ready}, 32'h0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        issue(OR, 3'd0, 7'h20, 32'd10, 32'd3, 32'h0, w);
        chk("b2b_accept_wait", 32'(w), 32'h0);
        wait_drain();

        // Flush mid-DIVU discards the operation.
        issue(OR, 3'd5, 7'h01, 32'hDEAD_BEEF, 32'd7, 32'h0, w);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_out_valid", {31'h0, out_valid}, 32'h0);
        chk("flush_in_ready", {31'h0, in_ready}, 32'h1);
        repeat (40) @(posedge clk);
        #1;
        issue(OR, 3'd0, 7'h00, 32'd1, 32'd1, 32'h0, w);
        wait_drain();

        // Reset mid-MUL discards the operation and clears rout.
        issue(OR, 3'd0, 7'h01, 32'h0001_0003, 32'h0000_0105, 32'h0, w);
        repeat (15) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_rout", rout, 32'h0);
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(7'b0110111, 3'd2, 7'h00, 32'h1, 32'h2, 32'h3, w);
        wait_drain();

        // Randomised traffic with random consumer back-pressure.
        rnd_rdy = 1'b1;
        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: begin op = OI; f7 = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00; end
                9:       begin op = 7'($urandom); f7 = 7'($urandom); end
                default: begin
                    op = OR;
                    case ($urandom_range(0, 4))
                        0:       f7 = 7'h00;
                        1:       f7 = 7'h20;
                        4:       f7 = 7'($urandom);
                        default: f7 = 7'h01;
                    endcase
                end
            endcase
            issue(op, 3'($urandom), f7, rnd_operand(), rnd_operand(), rnd_operand(), w);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
        rnd_rdy = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
